ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master arbiter that shares the single-port RAM between the CPU (master 0) and a DMA/loader engine (master 1). It sits between the memory bus's RAM-side port and the memory block. It forwards one access per cycle and stalls the losing master through a busy signal. Fairness uses a bounded-burst ownership policy, and read data is returned with a one-cycle latency tag per master.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grants to one master while the other is requesting; legal range ≥1.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. The write mask is `DATA_W/8` bits wide.

Ports:
- `clk` in 1: the single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `m0_addr_i` / `m1_addr_i` in `ADDR_W`: master address.
- `m0_rstrb_i` / `m1_rstrb_i` in 1: read strobe.
- `m0_wmask_i` / `m1_wmask_i` in `DATA_W/8`: byte write enables.
- `m0_wdata_i` / `m1_wdata_i` in `DATA_W`: write data.
- `m0_busy_o` / `m1_busy_o` out 1: request not granted this cycle; the master must hold its request.
- `m0_rvalid_o` / `m1_rvalid_o` out 1: `mX_rdata_o` holds this master's read result.
- `m0_rdata_o` / `m1_rdata_o` out `DATA_W`: both are driven from `ram_rdata_i`.
- `ram_addr_o` out `ADDR_W`, `ram_rstrb_o` out 1, `ram_wmask_o` out `DATA_W/8`, `ram_wdata_o` out `DATA_W`: granted access to the RAM.
- `ram_rdata_i` in `DATA_W`: RAM read data, valid the cycle after `ram_rstrb_o`.

## Operation
- **Request:** `reqX = mX_rstrb_i | (|mX_wmask_i)`.
  - Read and write in the same cycle form one access; both are forwarded.
- **State:**
  - `owner` is 1 bit, last granted master.
  - `cnt` is `$clog2(MAX_BURST+1)` bits, consecutive grants to `owner`, saturating at `MAX_BURST`.
- **Grant decision** (combinational, same cycle):
  - No request: no grant. RAM outputs are `rstrb=0` and `wmask=0`; addr/wdata are don't-care and driven from m0. `cnt<=0`, `owner` is held.
  - Only one master requests: grant it.
  - Both request and `cnt<MAX_BURST`: grant `owner`.
  - Both request and `cnt==MAX_BURST`: grant the other master.
- **Update on a grant:**
  - Granted master equals `owner`: `cnt<=sat(cnt+1)`.
  - Otherwise: `owner<=granted`, `cnt<=1`.
- **RAM mux:** `ram_*_o` carry the granted master's addr/rstrb/wmask/wdata unmodified.
- **Busy:** `mX_busy_o = reqX & ~gntX`. A master is never busy when it is not requesting.
  - While busy, the master holds addr/rstrb/wmask/wdata stable. The arbiter does not latch requests.
- **Read return:** the `rvalid_q[X]` register is set to `gntX & mX_rstrb_i`; `mX_rvalid_o = rvalid_q[X]`. At most one `rvalid` is high in any cycle.
- **Writes:** complete in the grant cycle, with no response.

## Timing
- Grant and busy are combinational from the requests and registered state, so there is zero added latency for the sole requester.
- Read latency is one cycle from the grant cycle to `rvalid` and data.
- Back-to-back grants are allowed every cycle, including alternating masters. Read data returns in grant order.
- **Worst-case wait:** `MAX_BURST` cycles while the other master requests continuously.
- **Reset (`rst` low, asynchronous):**
  - `owner=0`, `cnt=0`, `rvalid_q=0`.
  - All grants are forced to 0: `ram_rstrb_o=0`, `ram_wmask_o=0`, `busy=0`, `rvalid=0`.
  - A read granted in the cycle reset asserts is discarded and no `rvalid` follows.
- **Release:** the first cycle after `rst` deasserts arbitrates normally. With both requesting, m0 wins.
- **Saturation boundary:** `cnt` never exceeds `MAX_BURST`. A long solo run by one master lets the other master win immediately when it arrives.

## Test plan
- **Reset:** hold `rst=0` with both masters requesting. Required: all `ram_*` strobes 0, busy 0, rvalid 0. After release, m0 is granted first.
- **Sole reader:** m1 reads addr 0x100 with RAM data 0xDEADBEEF. Required: `m1_busy_o=0`, `ram_addr_o=0x100`, and the next cycle `m1_rvalid_o=1`, `m1_rdata_o=0xDEADBEEF`, `m0_rvalid_o=0`.
- **Continuous contention at `MAX_BURST=4`:** both masters request continuously from reset. Required grant sequence: m0×4, m1×4, m0×4. The busy signal of the non-granted master is 1 on every cycle of the other's burst.
- **Late arrival after saturation:** m0 reads alone for 10 cycles, then m1 joins. Required: m1 is granted in its first request cycle, `cnt=1`.
- **Write byte mask:** m0 writes `wmask=4'b0011`, `wdata=0x12345678`, addr 0x40, while m1 reads. Required: `ram_wmask_o=0011` with m0's data, and m1 is busy for exactly one cycle. m1's read then returns with `rvalid` one cycle after its grant.
- **Reset mid-read:** assert `rst` in the same cycle as a granted m0 read. Required: `m0_rvalid_o` stays 0; `owner` and `cnt` return to 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a shared single-port RAM (CPU = master 0, DMA = master 1).
// Bounded-burst fairness; grant is combinational, read valid returns one cycle later.
module ram_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic                m0_rstrb_i,
    input  logic [DATA_W/8-1:0] m0_wmask_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_busy_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic                m1_rstrb_i,
    input  logic [DATA_W/8-1:0] m1_wmask_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_busy_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic                ram_rstrb_o,
    output logic [DATA_W/8-1:0] ram_wmask_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    localparam int unsigned        CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_BURST);

    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             sel;

    assign req[0] = m0_rstrb_i | (|m0_wmask_i);
    assign req[1] = m1_rstrb_i | (|m1_wmask_i);

    // Grant decision; reset forces every grant low.
    always_comb begin
        gnt = 2'b00;
        sel = owner_q;
        if (rst) begin
            if (req[0] && req[1]) begin
                sel = (cnt_q < CNT_MAX) ? owner_q : ~owner_q;
                gnt = sel ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Ownership and burst-length tracking.
    always_comb begin
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rvalid_d = {gnt[1] & m1_rstrb_i, gnt[0] & m0_rstrb_i};
        if (gnt == 2'b00) begin
            cnt_d = '0;
        end else if (gnt[1] == owner_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            owner_d = gnt[1];
            cnt_d   = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 2'b00;
        end else begin
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // RAM-side mux; address/wdata default to m0 when idle.
    always_comb begin
        ram_addr_o  = gnt[1] ? m1_addr_i  : m0_addr_i;
        ram_wdata_o = gnt[1] ? m1_wdata_i : m0_wdata_i;
        ram_rstrb_o = 1'b0;
        ram_wmask_o = '0;
        if (gnt[1]) begin
            ram_rstrb_o = m1_rstrb_i;
            ram_wmask_o = m1_wmask_i;
        end else if (gnt[0]) begin
            ram_rstrb_o = m0_rstrb_i;
            ram_wmask_o = m0_wmask_i;
        end
    end

    assign m0_busy_o   = rst & req[0] & ~gnt[0];
    assign m1_busy_o   = rst & req[1] & ~gnt[1];
    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: run-length reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_ram_arbiter;

    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_rstrb, m1_rstrb;
    logic [STRB_W-1:0] m0_wmask, m1_wmask;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_busy_o, m1_busy_o, m0_rvalid_o, m1_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_rstrb_o;
    logic [STRB_W-1:0] ram_wmask_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic started  = 1'b0;

    ram_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m0_rstrb_i(m0_rstrb), .m0_wmask_i(m0_wmask), .m0_wdata_i(m0_wdata),
        .m0_busy_o(m0_busy_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_addr_i(m1_addr), .m1_rstrb_i(m1_rstrb), .m1_wmask_i(m1_wmask), .m1_wdata_i(m1_wdata),
        .m1_busy_o(m1_busy_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_rstrb_o(ram_rstrb_o), .ram_wmask_o(ram_wmask_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Physical RAM model: sample the bus mid-cycle, act on the next rising edge.
    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic        ram_rd_p = 1'b0;
    logic [7:0]  ram_idx_p = '0;
    logic [3:0]  ram_wm_p = '0;
    logic [31:0] ram_wd_p = '0;

    always @(negedge clk) begin
        ram_rd_p  <= ram_rstrb_o;
        ram_idx_p <= ram_addr_o[9:2];
        ram_wm_p  <= ram_wmask_o;
        ram_wd_p  <= ram_wdata_o;
    end

    always @(posedge clk) begin
        if (ram_rd_p) ram_rdata_i <= mem[ram_idx_p];
        if (|ram_wm_p) mem[ram_idx_p] <= merge(mem[ram_idx_p], ram_wd_p, ram_wm_p);
    end

    // Reference model: last winner and unbounded length of its current run.
    int          m_last = 0;
    int          m_run  = 0;
    logic [1:0]  m_rv   = 2'b00;
    logic [31:0] m_rdata = '0;

    function automatic int model_grant();
        logic r0, r1;
        r0 = m0_rstrb | (|m0_wmask);
        r1 = m1_rstrb | (|m1_wmask);
        if (rst !== 1'b1) return -1;
        if (r0 && r1) return (m_run >= int'(MAX_BURST)) ? 1 - m_last : m_last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int          g;
        logic [31:0] a, wd;
        logic [3:0]  wm;
        logic        rs;
        if (!rst) begin
            m_last <= 0;
            m_run  <= 0;
            m_rv   <= 2'b00;
        end else begin
            g  = model_grant();
            a  = (g == 1) ? m1_addr  : m0_addr;
            wd = (g == 1) ? m1_wdata : m0_wdata;
            wm = (g == 1) ? m1_wmask : m0_wmask;
            rs = (g == 1) ? m1_rstrb : m0_rstrb;
            m_rv <= {(g == 1) && m1_rstrb, (g == 0) && m0_rstrb};
            if (g < 0) begin
                m_run <= 0;
            end else begin
                if (rs) m_rdata <= exp_mem[a[9:2]];
                if (|wm) exp_mem[a[9:2]] <= merge(exp_mem[a[9:2]], wd, wm);
                if (g == m_last) begin
                    m_run <= m_run + 1;
                end else begin
                    m_last <= g;
                    m_run  <= 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int   g;
        logic r0, r1;
        if (started) begin
            g  = model_grant();
            r0 = m0_rstrb | (|m0_wmask);
            r1 = m1_rstrb | (|m1_wmask);
            chk("m_busy0", m0_busy_o, 64'((rst === 1'b1) && r0 && g != 0));
            chk("m_busy1", m1_busy_o, 64'((rst === 1'b1) && r1 && g != 1));
            chk("m_rstrb", ram_rstrb_o, 64'((g == 0) ? m0_rstrb : (g == 1) ? m1_rstrb : 1'b0));
            chk("m_wmask", ram_wmask_o, 64'((g == 0) ? m0_wmask : (g == 1) ? m1_wmask : 4'h0));
            if (g >= 0) begin
                chk("m_addr",  ram_addr_o,  64'((g == 1) ? m1_addr  : m0_addr));
                chk("m_wdata", ram_wdata_o, 64'((g == 1) ? m1_wdata : m0_wdata));
            end
            chk("m_rvalid", {m1_rvalid_o, m0_rvalid_o}, 64'(m_rv));
            if (m_rv[0]) chk("m_rdata0", m0_rdata_o, 64'(m_rdata));
            if (m_rv[1]) chk("m_rdata1", m1_rdata_o, 64'(m_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic rs, input logic [3:0] wm, input logic [31:0] a,
                          input logic [31:0] wd);
        m0_rstrb = rs; m0_wmask = wm; m0_addr = a; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic rs, input logic [3:0] wm, input logic [31:0] a,
                          input logic [31:0] wd);
        m1_rstrb = rs; m1_wmask = wm; m1_addr = a; m1_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h5A000000 | 32'(i);
            exp_mem[i] = 32'h5A000000 | 32'(i);
        end
        mem[64] = 32'hDEADBEEF; exp_mem[64] = 32'hDEADBEEF;
        mem[16] = 32'hAAAAAAAA; exp_mem[16] = 32'hAAAAAAAA;
        mem[17] = 32'hCAFEF00D; exp_mem[17] = 32'hCAFEF00D;

        // Reset held with both masters requesting.
        rst = 1'b0;
        set_m0(1'b1, 4'h0, 32'h10, 32'h0);
        set_m1(1'b1, 4'h0, 32'h20, 32'h0);
        repeat (3) tick();
        started = 1'b1;
        @(negedge clk);
        chk("rst_rstrb", ram_rstrb_o, 64'(0));
        chk("rst_wmask", ram_wmask_o, 64'(0));
        chk("rst_busy", {m1_busy_o, m0_busy_o}, 64'(0));
        chk("rst_rvalid", {m1_rvalid_o, m0_rvalid_o}, 64'(0));
        tick();
        rst = 1'b1;

        // Continuous contention: m0 x4, m1 x4, m0 x4.
        for (int k = 0; k < 12; k++) begin
            logic exp0;
            exp0 = (k < 4) || (k >= 8);
            @(negedge clk);
            chk("contend_addr", ram_addr_o, exp0 ? 64'h10 : 64'h20);
            chk("contend_busy", exp0 ? m1_busy_o : m0_busy_o, 64'(1));
            tick();
        end
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Sole reader on m1.
        set_m1(1'b1, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        chk("solo_busy", m1_busy_o, 64'(0));
        chk("solo_addr", ram_addr_o, 64'h100);
        tick();
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("solo_rvalid1", m1_rvalid_o, 64'(1));
        chk("solo_rdata1", m1_rdata_o, 64'hDEADBEEF);
        chk("solo_rvalid0", m0_rvalid_o, 64'(0));
        tick();

        // Late arrival after a long solo run by m0.
        set_m0(1'b1, 4'h0, 32'h10, 32'h0);
        repeat (10) tick();
        set_m1(1'b1, 4'h0, 32'h20, 32'h0);
        @(negedge clk);
        chk("late_addr", ram_addr_o, 64'h20);
        chk("late_busy0", m0_busy_o, 64'(1));
        tick();
        chk("late_cnt", dut.cnt_q, 64'(1));
        chk("late_owner", dut.owner_q, 64'(1));
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        set_m0(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Masked write by m0 while m1 reads.
        set_m0(1'b0, 4'b0011, 32'h40, 32'h12345678);
        set_m1(1'b1, 4'h0, 32'h44, 32'h0);
        @(negedge clk);
        chk("wr_wmask", ram_wmask_o, 64'h3);
        chk("wr_wdata", ram_wdata_o, 64'h12345678);
        chk("wr_addr", ram_addr_o, 64'h40);
        chk("wr_busy1", m1_busy_o, 64'(1));
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wr_busy1_clr", m1_busy_o, 64'(0));
        chk("wr_rd_addr", ram_addr_o, 64'h44);
        chk("wr_rvalid_early", m1_rvalid_o, 64'(0));
        tick();
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wr_rvalid1", m1_rvalid_o, 64'(1));
        chk("wr_rdata1", m1_rdata_o, 64'hCAFEF00D);
        tick();
        set_m0(1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wr_readback", m0_rdata_o, 64'hAAAA5678);
        tick();

        // Reset lands in the same cycle as a granted m0 read.
        set_m1(1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        set_m1(1'b0, 4'h0, 32'h0, 32'h0);
        set_m0(1'b1, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("mid_rstrb", ram_rstrb_o, 64'(1));
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rvalid0", m0_rvalid_o, 64'(0));
        chk("mid_owner", dut.owner_q, 64'(0));
        chk("mid_cnt", dut.cnt_q, 64'(0));
        tick();
        rst = 1'b1;
        set_m0(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
